// File: rtl/bmc_soft_nx.sv
// Soft-decision branch metric unit, rate 1/N, two-stage valid/ready pipe.
// Optional min-normalisation of the metrics: define BMC_MIN_NORM_EN.
module bmc_soft_nx #(
  parameter int N = 2,
  parameter int Q = 3,
  localparam int BMW = Q + $clog2(N),
  localparam int H = 1 << N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [N*Q-1:0]   rx_sym,
  input  logic [N-1:0]     rx_erase,
  input  logic             rx_last,
  output logic             bm_valid,
  input  logic             bm_ready,
  output logic [H*BMW-1:0] bm_out,
  output logic             bm_last
);

  localparam logic [Q-1:0] SMAX = '1;

  logic             a_valid;
  logic [N*Q-1:0]   a_sym;
  logic [N-1:0]     a_erase;
  logic             a_last;
  logic             b_load;
  logic             a_adv;
  logic             rx_fire;
  logic [BMW-1:0]   raw [H];
  logic [H*BMW-1:0] bm_next;

  // Handshake: B frees when empty or drained, A empties into B
  always_comb begin
    b_load   = !bm_valid || bm_ready;
    a_adv    = a_valid && b_load;
    rx_ready = !a_valid || a_adv;
    rx_fire  = rx_valid && rx_ready;
  end

  // Per-hypothesis sum of soft distances, erased symbols count zero
  always_comb begin
    logic [BMW-1:0] acc;
    logic [Q-1:0]   s;
    logic [Q-1:0]   d;
    logic [N-1:0]   hv;
    for (int h = 0; h < H; h++) begin
      hv  = N'(h);
      acc = '0;
      for (int i = 0; i < N; i++) begin
        s = a_sym[i*Q +: Q];
        d = hv[i] ? (SMAX - s) : s;
        if (!a_erase[i]) begin
          acc = acc + BMW'(d);
        end
      end
      raw[h] = acc;
    end
  end

`ifdef BMC_MIN_NORM_EN
  // Subtract the smallest metric so the best branch reads zero
  always_comb begin
    logic [BMW-1:0] mn;
    mn = raw[0];
    for (int h = 1; h < H; h++) begin
      if (raw[h] < mn) begin
        mn = raw[h];
      end
    end
    bm_next = '0;
    for (int h = 0; h < H; h++) begin
      bm_next[h*BMW +: BMW] = raw[h] - mn;
    end
  end
`else
  // Raw metrics go straight to stage B
  always_comb begin
    bm_next = '0;
    for (int h = 0; h < H; h++) begin
      bm_next[h*BMW +: BMW] = raw[h];
    end
  end
`endif

  // Stage A captures input, stage B holds metrics until drained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_sym    <= '0;
      a_erase  <= '0;
      a_last   <= 1'b0;
      bm_valid <= 1'b0;
      bm_out   <= '0;
      bm_last  <= 1'b0;
    end else begin
      if (rx_fire) begin
        a_valid <= 1'b1;
        a_sym   <= rx_sym;
        a_erase <= rx_erase;
        a_last  <= rx_last;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
      if (b_load) begin
        bm_valid <= a_valid;
        if (a_valid) begin
          bm_out  <= bm_next;
          bm_last <= a_last;
        end
      end
    end
  end

endmodule
